lfsr_rng_server: RTL and testbench

Shared pseudo-random number server built around the team's 8-bit Fibonacci LFSR (taps 7,5,4,3). It sequences the LFSR through seeding and warm-up, then hands out one 8-bit random word per grant to NREQ requesters with round-robin arbitration. It sits between the LFSR datapath and the test-pattern, scrambler and dither clients that need random bytes without each owning a generator.

---
 rtl/lfsr_rng_server.sv | 121 ++++++++++++
 tb/tb_lfsr_rng_server.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_server.sv
// lfsr_rng_server: shared 8-bit Fibonacci LFSR (taps 7,5,4,3)
// handing out one random byte per grant to NREQ requesters, round-robin.
module lfsr_rng_server #(
    parameter int          NREQ         = 4,
    parameter logic [7:0]  SEED_DEFAULT = 8'hAA,
    parameter int          WARMUP       = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [7:0]      rnd_data,
    output logic            rnd_valid,
    input  logic            seed_valid,
    input  logic [7:0]      seed_data,
    output logic            seed_ready,
    output logic            busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_SERVE  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      s_q, s_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic [PW-1:0]   pick;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // First set request bit at or above p, wrapping modulo NREQ.
    function automatic logic [PW-1:0] rr_pick(
        input logic [NREQ-1:0] r,
        input logic [PW-1:0]   p
    );
        logic [PW-1:0] res;
        logic          done;
        int            idx;
        res  = '0;
        done = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(p) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!done && r[idx]) begin
                res  = idx[PW-1:0];
                done = 1'b1;
            end
        end
        return res;
    endfunction

    assign pick       = rr_pick(req, ptr_q);
    assign gnt        = gnt_q;
    assign rnd_data   = data_q;
    assign rnd_valid  = valid_q;
    assign seed_ready = (state_q == ST_SERVE);
    assign busy       = (state_q == ST_WARMUP);

    // Next-state: warm-up stepping, seed loading and round-robin grants.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        valid_d = 1'b0;
        data_d  = data_q;
        unique case (state_q)
            ST_WARMUP: begin
                s_d   = lfsr_next(s_q);
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = ST_SERVE;
            end
            ST_SERVE: begin
                if (seed_valid) begin
                    s_d     = (seed_data == 8'h00) ? SEED_DEFAULT : seed_data;
                    cnt_d   = 8'(WARMUP);
                    state_d = ST_WARMUP;
                end else if (|req) begin
                    gnt_d[pick] = 1'b1;
                    valid_d     = 1'b1;
                    data_d      = s_q;
                    s_d         = lfsr_next(s_q);
                    ptr_d       = (pick == PW'(NREQ - 1)) ? '0 : pick + PW'(1);
                end
            end
            default: state_d = ST_WARMUP;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WARMUP;
            s_q     <= SEED_DEFAULT;
            cnt_q   <= 8'(WARMUP);
            ptr_q   <= '0;
            gnt_q   <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_lfsr_rng_server.sv
// tb_lfsr_rng_server: scoreboard bench with a behavioural RNG-server model,
// directed scenarios followed by randomized traffic.
module tb_lfsr_rng_server;

    localparam int         NREQ = 4;
    localparam int         W    = 8;
    localparam logic [7:0] SD   = 8'hAA;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic [7:0]      rnd_data;
    logic            rnd_valid;
    logic            seed_valid = 1'b0;
    logic [7:0]      seed_data = 8'h00;
    logic            seed_ready;
    logic            busy;

    lfsr_rng_server #(.NREQ(NREQ), .SEED_DEFAULT(SD), .WARMUP(W)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .rnd_data(rnd_data), .rnd_valid(rnd_valid),
        .seed_valid(seed_valid), .seed_data(seed_data),
        .seed_ready(seed_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NREQ-1:0] g;
        logic [7:0]      d;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    bit   mon_on = 1'b0;

    // Reference model state
    logic [7:0] m_rng;
    int         m_warm;
    int         m_ptr;

    logic [NREQ-1:0] last_gnt;
    logic [7:0]      last_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic logic [7:0] rng_adv(input logic [7:0] v);
        logic [8:0] sh;
        sh = {1'b0, v} * 2;
        return sh[7:0] | {7'b0, ^(v & 8'hB8)};
    endfunction

    // One clock cycle: check status, drive inputs, advance the model.
    task automatic step(input logic r, input logic [NREQ-1:0] rq,
                        input logic sv, input logic [7:0] sd);
        int   pk;
        exp_t e;
        @(negedge clk);
        if (mon_on) begin
            chk("busy", busy, m_warm > 0);
            chk("seed_ready", seed_ready, m_warm == 0);
        end
        rst = r; req = rq; seed_valid = sv; seed_data = sd;
        if (r) begin
            m_rng = SD; m_warm = W; m_ptr = 0;
        end else if (m_warm > 0) begin
            m_rng = rng_adv(m_rng); m_warm--;
        end else if (sv) begin
            m_rng = (sd == 0) ? SD : sd; m_warm = W;
        end else if (rq != 0) begin
            pk = -1;
            for (int k = 0; k < NREQ; k++)
                if (pk < 0 && rq[(m_ptr + k) % NREQ]) pk = (m_ptr + k) % NREQ;
            e.g = '0;
            e.g[pk] = 1'b1;
            e.d = m_rng;
            sb.push_back(e);
            m_rng = rng_adv(m_rng);
            m_ptr = (pk + 1) % NREQ;
        end
        @(posedge clk);
        if (r) mon_on = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        step(1'b1, '0, 1'b0, 8'h00);
        step(1'b1, '0, 1'b0, 8'h00);
        #3;
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", rnd_valid, 0);
        chk("rst_data", rnd_data, 0);
        chk("rst_busy", busy, 1);
        chk("rst_seed_ready", seed_ready, 0);
    endtask

    task automatic grant_is(input string name, input logic [NREQ-1:0] rq,
                            input logic [NREQ-1:0] g, input logic [7:0] d);
        step(1'b0, rq, 1'b0, 8'h00);
        #3;
        chk({name, "_gnt"}, last_gnt, g);
        chk({name, "_data"}, last_data, d);
    endtask

    // Monitor: pop and compare whenever the DUT presents a grant.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (mon_on) begin
                last_gnt  = gnt;
                last_data = rnd_data;
                chk("valid_vs_gnt", rnd_valid, |gnt);
                if (rnd_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_grant", gnt, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_gnt", gnt, e.g);
                        chk("sb_data", rnd_data, e.d);
                    end
                end else if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("missed_grant", gnt, e.g);
                end
            end
        end
    end

    initial begin
        logic [NREQ-1:0] rq;
        logic            sv;
        logic            rr;
        m_rng = SD; m_warm = W; m_ptr = 0;

        // Reset, warm-up, single grants
        do_reset();
        idle(W);
        #3;
        chk("served_ready", seed_ready, 1);
        grant_is("first", 4'b0001, 4'b0001, 8'hF9);
        grant_is("second", 4'b0001, 4'b0001, 8'hF2);

        // All requesters held: rotate
        do_reset();
        idle(W);
        grant_is("rr0", 4'b1111, 4'b0001, 8'hF9);
        grant_is("rr1", 4'b1111, 4'b0010, 8'hF2);
        grant_is("rr2", 4'b1111, 4'b0100, 8'hE5);
        grant_is("rr3", 4'b1111, 4'b1000, 8'hCA);
        grant_is("rr4", 4'b1111, 4'b0001, 8'h94);

        // Reseed with 0x01, then zero seed
        step(1'b0, '0, 1'b1, 8'h01);
        #3;
        chk("seed_busy", busy, 1);
        idle(W);
        grant_is("seed01", 4'b0001, 4'b0001, 8'h1C);
        step(1'b0, '0, 1'b1, 8'h00);
        idle(W);
        grant_is("seed00", 4'b0001, 4'b0001, 8'hF9);

        // Seed and request in the same cycle
        step(1'b0, 4'b0100, 1'b1, 8'h37);
        #3;
        chk("seedreq_nogrant", last_gnt, 0);
        chk("seedreq_busy", busy, 1);
        for (int i = 0; i < W; i++) step(1'b0, 4'b0100, 1'b0, 8'h00);
        step(1'b0, 4'b0100, 1'b0, 8'h00);
        #3;
        chk("seedreq_later", last_gnt, 4'b0100);

        // Pointer at 2 with req[1] and req[3]
        step(1'b0, 4'b0010, 1'b0, 8'h00);
        step(1'b0, 4'b1010, 1'b0, 8'h00);
        #3;
        chk("ptr2_first", last_gnt, 4'b1000);
        step(1'b0, 4'b1010, 1'b0, 8'h00);
        #3;
        chk("ptr2_second", last_gnt, 4'b0010);

        // Reset mid warm-up after seeding 0x01
        step(1'b0, '0, 1'b1, 8'h01);
        idle(3);
        do_reset();
        idle(W);
        grant_is("after_rst", 4'b0001, 4'b0001, 8'hF9);

        // Reset while a grant is pending
        step(1'b0, 4'b0011, 1'b0, 8'h00);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rq = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            if ($urandom_range(0, 3) == 0) rq = '0;
            sv = ($urandom_range(0, 19) == 0);
            rr = ($urandom_range(0, 99) == 0);
            step(rr, rq, sv, 8'($urandom_range(0, 255)));
        end

        idle(3);
        #3;
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
